// File: rtl/rhs_spi_master_multi_if.sv
// Bus bundle for rhs_spi_master_multi: command FIFO handshake, SPI pins and parallel receive words.
// frame_cnt exists only when RHS_SPI_FRAME_CNT_EN is defined.
interface rhs_spi_master_multi_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_CHIPS = 4
);
  logic                          cmd_valid;
  logic [WORD_W-1:0]             cmd_data;
  logic                          cmd_ready;
  logic [7:0]                    oversample_offset;
  logic                          SCLK;
  logic                          MOSI;
  logic                          CS;
  logic [NUM_CHIPS-1:0]          MISO;
  logic                          rx_valid;
  logic [NUM_CHIPS*WORD_W-1:0]   rx_data;
  logic                          busy;
`ifdef RHS_SPI_FRAME_CNT_EN
  logic [15:0]                   frame_cnt;

  modport master (
    input  cmd_valid, cmd_data, oversample_offset, MISO,
    output cmd_ready, SCLK, MOSI, CS, rx_valid, rx_data, busy, frame_cnt
  );
  modport slave (
    output cmd_valid, cmd_data, oversample_offset, MISO,
    input  cmd_ready, SCLK, MOSI, CS, rx_valid, rx_data, busy, frame_cnt
  );
`else
  modport master (
    input  cmd_valid, cmd_data, oversample_offset, MISO,
    output cmd_ready, SCLK, MOSI, CS, rx_valid, rx_data, busy
  );
  modport slave (
    output cmd_valid, cmd_data, oversample_offset, MISO,
    input  cmd_ready, SCLK, MOSI, CS, rx_valid, rx_data, busy
  );
`endif
endinterface

// File: rtl/rhs_spi_master_multi.sv
// Multi-chip SPI master for RHS headstages: FIFO-buffered commands, shared SCLK/CS/MOSI, per-chip MISO
// sampled at a programmable delay after each SCLK rise. Optional frame counter: RHS_SPI_FRAME_CNT_EN.
//
// state    | meaning
// IDLE     | waiting for a command; pops FIFO, latches word and clamped sample offset
// CS_SETUP | CS low, MOSI = MSB, SCLK low for HALF_DIV cycles
// SHIFT    | WORD_W SCLK periods, MOSI advances on each SCLK fall
// CS_HOLD  | SCLK low, CS still low until the last delayed MISO sample has landed
// CS_HIGH  | CS high, MOSI low for CS_HIGH_CYC cycles
module rhs_spi_master_multi #(
  parameter int WORD_W      = 32,
  parameter int NUM_CHIPS   = 4,
  parameter int HALF_DIV    = 3,
  parameter int CS_HIGH_CYC = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_OFFSET  = 15
) (
  input logic                    clk,
  input logic                    rstn,
  rhs_spi_master_multi_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OFFSET + 1);
  localparam int BW = $clog2(WORD_W);
  localparam int SW = $clog2(WORD_W + 1);
  localparam int CW = 8;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_HIGH} state_t;
  state_t state;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, push, pop;

  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push          = bus.cmd_valid && !full;
  assign pop           = (state == IDLE) && !empty;
  assign bus.cmd_ready = !full;
  assign bus.busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.cmd_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic [OW-1:0]     off, off_next;
  logic [CW-1:0]     cnt, hold_len;
  logic              phase_hi;
  logic [BW-1:0]     bit_cnt;
  logic [WORD_W-1:0] sh;
  logic              rise_now;

  assign off_next = (bus.oversample_offset > 8'(MAX_OFFSET)) ? OW'(MAX_OFFSET)
                                                              : bus.oversample_offset[OW-1:0];
  // Hold CS low long enough for the last bit's delayed sample: max(HALF_DIV, off+1)
  assign hold_len = (CW'(off) >= CW'(HALF_DIV)) ? CW'(off) + 1'b1 : CW'(HALF_DIV);
  assign rise_now = (state == SHIFT) && !phase_hi && (cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      phase_hi <= 1'b0;
      bit_cnt  <= '0;
      sh       <= '0;
      off      <= '0;
      bus.SCLK <= 1'b0;
      bus.MOSI <= 1'b0;
      bus.CS   <= 1'b1;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          sh       <= mem[rd_ptr[AW-1:0]];
          bus.MOSI <= mem[rd_ptr[AW-1:0]][WORD_W-1];
          off      <= off_next;
          bus.CS   <= 1'b0;
          cnt      <= CW'(HALF_DIV - 1);
          state    <= CS_SETUP;
        end
        CS_SETUP: if (cnt == '0) begin
          cnt      <= CW'(HALF_DIV - 1);
          phase_hi <= 1'b0;
          bit_cnt  <= BW'(WORD_W - 1);
          state    <= SHIFT;
        end else cnt <= cnt - 1'b1;
        SHIFT: if (cnt != '0) cnt <= cnt - 1'b1;
        else if (!phase_hi) begin
          bus.SCLK <= 1'b1;
          phase_hi <= 1'b1;
          cnt      <= CW'(HALF_DIV - 1);
        end else begin
          bus.SCLK <= 1'b0;
          phase_hi <= 1'b0;
          if (bit_cnt == '0) begin
            cnt   <= hold_len - 1'b1;
            state <= CS_HOLD;
          end else begin
            bit_cnt  <= bit_cnt - 1'b1;
            sh       <= {sh[WORD_W-2:0], 1'b0};
            bus.MOSI <= sh[WORD_W-2];
            cnt      <= CW'(HALF_DIV - 1);
          end
        end
        CS_HOLD: if (cnt == '0) begin
          bus.CS   <= 1'b1;
          bus.MOSI <= 1'b0;
          cnt      <= CW'(CS_HIGH_CYC - 1);
          state    <= CS_HIGH;
        end else cnt <= cnt - 1'b1;
        CS_HIGH: if (cnt == '0) state <= IDLE;
        else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // taps[0] is the SCLK-rise edge itself; taps[n] fires n cycles later
  logic [NUM_CHIPS-1:0]              miso_s1, miso_s2;
  logic [MAX_OFFSET-1:0]             dly;
  logic [MAX_OFFSET:0]               taps;
  logic                              samp;
  logic [SW-1:0]                     samp_cnt;
  logic [NUM_CHIPS-1:0][WORD_W-1:0]  rx_sh, rx_next;

  assign taps = {dly, rise_now};
  assign samp = taps[off];

  always_comb begin
    rx_next = rx_sh;
    for (int k = 0; k < NUM_CHIPS; k++) rx_next[k] = {rx_sh[k][WORD_W-2:0], miso_s2[k]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miso_s1      <= '0;
      miso_s2      <= '0;
      dly          <= '0;
      samp_cnt     <= '0;
      rx_sh        <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      miso_s1      <= bus.MISO;
      miso_s2      <= miso_s1;
      dly          <= taps[MAX_OFFSET-1:0];
      bus.rx_valid <= 1'b0;
      if (pop) samp_cnt <= '0;
      else if (samp) begin
        samp_cnt <= samp_cnt + 1'b1;
        rx_sh    <= rx_next;
        if (samp_cnt == SW'(WORD_W - 1)) begin
          bus.rx_valid <= 1'b1;
          bus.rx_data  <= rx_next;
        end
      end
    end
  end

`ifdef RHS_SPI_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bus.frame_cnt <= '0;
    else if (bus.rx_valid) bus.frame_cnt <= bus.frame_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_rhs_spi_master_multi.sv
// Directed bench for rhs_spi_master_multi: vector table of single frames against an echo/lookup slave,
// plus FIFO overflow, mid-frame offset change and mid-frame reset sequences.
module tb_rhs_spi_master_multi;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rhs_spi_master_multi_if bus ();
  rhs_spi_master_multi dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [31:0]  cmd;
    logic [7:0]   off;
    int           dly;
    bit           tbl;
    logic [127:0] exp_rx;
    int           exp_cs_low;
  } vec_t;
  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;

  // slave model and bus monitor state
  int           dly_cfg = 0;
  bit           tbl_mode = 1'b0;
  logic [31:0]  resp [4];
  logic [63:0]  hist = '0;
  bit           prev_cs = 1'b1, prev_sclk = 1'b0;
  int           rx_cnt = 0, rv_run = 0, last_rv_width = 0;
  int           cs_low_run = 0, last_cs_low = 0, cs_high_run = 0, min_gap = 1000;
  int           rise_run = 0, last_rises = 0, cur_idx = 31, mosi_bits = 0;
  logic [31:0]  mosi_word = '0;
  logic [31:0]  mosi_q [$];
  logic [127:0] last_rx = '0;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (rv_run == 0) begin
        rx_cnt++;
        last_rx = bus.rx_data;
      end
      rv_run++;
    end else if (rv_run != 0) begin
      last_rv_width = rv_run;
      rv_run = 0;
    end
    if (!bus.CS) begin
      if (prev_cs) begin
        if (cs_high_run < min_gap) min_gap = cs_high_run;
        cs_low_run = 0; rise_run = 0; mosi_bits = 0; cur_idx = 31;
      end
      cs_low_run++;
      if (bus.SCLK && !prev_sclk) begin
        rise_run++;
        mosi_word = {mosi_word[30:0], bus.MOSI};
        mosi_bits++;
      end
      if (!bus.SCLK && prev_sclk && cur_idx > 0) cur_idx--;
    end else begin
      if (!prev_cs) begin
        last_cs_low = cs_low_run;
        last_rises  = rise_run;
        if (mosi_bits == 32) mosi_q.push_back(mosi_word);
        cs_high_run = 0;
      end
      cs_high_run++;
      cur_idx = 31;
    end
    prev_cs   = bus.CS;
    prev_sclk = bus.SCLK;
    hist = {hist[62:0], bus.MOSI};
    for (int k = 0; k < 4; k++) bus.MISO[k] = tbl_mode ? resp[k][cur_idx] : hist[dly_cfg];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rx(input int start, input string name);
    int t = 0;
    while (rx_cnt == start && t < 2000) begin tick(); t++; end
    check({name, "_rx_seen"}, rx_cnt > start, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((bus.busy || !bus.CS) && t < 8000) begin tick(); t++; end
    tick();
    check({name, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic push(input logic [31:0] w);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = w;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  int          start, acc, t, fc_base;
  bit          saw_full;
  logic [31:0] words [17];
  logic [31:0] exp_q [$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) resp[k] = 32'h1000_0000 * k + k;
    vecs[0] = '{32'hDEADBEEF, 8'd0,   0, 1'b0, {4{32'hDEADBEEF}}, 198};
    vecs[1] = '{32'hDEADBEEF, 8'd5,   5, 1'b0, {4{32'hDEADBEEF}}, 201};
    vecs[2] = '{32'hDEADBEEF, 8'd0,   5, 1'b0, {4{32'h6F56DF77}}, 198};
    vecs[3] = '{32'hDEADBEEF, 8'd200, 5, 1'b0, {4{32'hBD5B7DDF}}, 211};
    vecs[4] = '{32'hDEADBEEF, 8'd16,  5, 1'b0, {4{32'hBD5B7DDF}}, 211};
    vecs[5] = '{32'hDEADBEEF, 8'd15,  5, 1'b0, {4{32'hBD5B7DDF}}, 211};
    vecs[6] = '{32'h12345678, 8'd3,   3, 1'b0, {4{32'h12345678}}, 199};
    vecs[7] = '{32'h00000000, 8'd0,   0, 1'b1,
                {32'h30000003, 32'h20000002, 32'h10000001, 32'h00000000}, 198};
    vecs[8] = '{32'hFFFFFFFF, 8'd2,   0, 1'b0, {4{32'hFFFFFFFF}}, 198};
    vecs[9] = '{32'h0F0F0F0F, 8'd6,   0, 1'b0, {4{32'h1E1E1E1F}}, 202};

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.oversample_offset = 8'd0;
    repeat (4) tick();
    check("rst_cs", bus.CS, 1'b1);
    check("rst_sclk", bus.SCLK, 1'b0);
    check("rst_mosi", bus.MOSI, 1'b0);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_data", bus.rx_data, 128'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    rstn = 1'b1;
    fc_base = 0;
    tick();

    for (int i = 0; i < 10; i++) begin
      wait_idle($sformatf("v%0d_pre", i));
      dly_cfg  = vecs[i].dly;
      tbl_mode = vecs[i].tbl;
      bus.oversample_offset = vecs[i].off;
      start = rx_cnt;
      push(vecs[i].cmd);
      check($sformatf("v%0d_busy", i), bus.busy, 1'b1);
      wait_rx(start, $sformatf("v%0d", i));
      check($sformatf("v%0d_rx", i), last_rx, vecs[i].exp_rx);
      wait_idle($sformatf("v%0d_post", i));
      check($sformatf("v%0d_cs_low", i), last_cs_low, vecs[i].exp_cs_low);
      check($sformatf("v%0d_rv_width", i), last_rv_width, 1);
      check($sformatf("v%0d_rises", i), last_rises, 32);
      check($sformatf("v%0d_rx_held", i), bus.rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d_pulses", i), rx_cnt - start, 1);
    end
    tbl_mode = 1'b0;

    // offset change mid-frame must not affect the frame in flight
    dly_cfg = 5;
    bus.oversample_offset = 8'd5;
    start = rx_cnt;
    push(32'hDEADBEEF);
    t = 0;
    while (bus.CS && t < 100) begin tick(); t++; end
    bus.oversample_offset = 8'd0;
    wait_rx(start, "offchg");
    check("offchg_rx", last_rx, {4{32'hDEADBEEF}});
    wait_idle("offchg");
    check("offchg_cs_low", last_cs_low, 201);

    // FIFO fill while a frame is in flight: 16 stored, 17th dropped, order preserved
    dly_cfg = 0;
    bus.oversample_offset = 8'd0;
    mosi_q.delete();
    exp_q.delete();
    for (int i = 0; i < 17; i++) words[i] = (32'h0101_0101 * (i + 1)) ^ 32'hA500_0000;
    start = rx_cnt;
    push(32'h5A5A_C3C3);
    exp_q.push_back(32'h5A5A_C3C3);
    t = 0;
    while (bus.CS && t < 100) begin tick(); t++; end
    min_gap = 1000;
    acc = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = words[i];
      if (bus.cmd_ready) acc++;
      else if (i == 16) saw_full = 1'b1;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("burst_accepted", acc, 16);
    check("burst_ready_low_full", saw_full, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(words[i]);
    for (int f = 0; f < 17; f++) begin
      wait_rx(start + f, $sformatf("burst%0d", f));
      check($sformatf("burst%0d_rx", f), last_rx, {4{exp_q[f]}});
    end
    wait_idle("burst");
    repeat (400) tick();
    check("burst_pulses", rx_cnt - start, 17);
    check("burst_mosi_cnt", mosi_q.size(), 17);
    for (int f = 0; f < 17 && f < mosi_q.size(); f++)
      check($sformatf("burst%0d_mosi", f), mosi_q[f], exp_q[f]);
    check("burst_cs_gap_ge8", min_gap >= 8, 1'b1);

`ifdef RHS_SPI_FRAME_CNT_EN
    check("frame_cnt", bus.frame_cnt, 16'(rx_cnt - fc_base));
`endif

    // reset during bit 12 aborts the frame without an rx_valid
    start = rx_cnt;
    push(32'hCAFEF00D);
    t = 0;
    while (!(bus.CS == 1'b0 && cur_idx == 12) && t < 2000) begin tick(); t++; end
    check("abort_reached_bit12", cur_idx, 12);
    rstn = 1'b0;
    #1;
    check("abort_cs", bus.CS, 1'b1);
    check("abort_sclk", bus.SCLK, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_rx_data", bus.rx_data, 128'h0);
    repeat (3) tick();
    rstn = 1'b1;
    fc_base = rx_cnt;
    repeat (300) tick();
    check("abort_no_rx", rx_cnt - start, 0);
    check("abort_mosi", bus.MOSI, 1'b0);
    push(32'h0BADCAFE);
    wait_rx(start, "after_abort");
    check("after_abort_rx", last_rx, {4{32'h0BADCAFE}});
    wait_idle("after_abort");
    check("after_abort_cs_low", last_cs_low, 198);

`ifdef RHS_SPI_FRAME_CNT_EN
    check("frame_cnt_after_reset", bus.frame_cnt, 16'(rx_cnt - fc_base));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
